// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Captures the N aligned result rows of an NxN matrix product from the output
// deskew stage, then streams the matrix out in row-major order over a
// valid/ready handshake and pulses done after the last element is accepted.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   enable     pipeline advance qualifier; only WAIT and CAPTURE honour it
//   start      single-cycle pulse on the first cycle of a computation
//   row_in     aligned result row, element j = column j
//   out_data   streamed element (0 when not draining)
//   out_valid  out_data is valid
//   out_ready  consumer ready; a beat transfers when out_valid && out_ready
//   out_last   marks the final element C[N-1][N-1]
//   busy       state is not IDLE
//   done       one-cycle pulse after the final handshake
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, out_data and
// out_last hold their values; out_valid never drops until its beat transfers.
// -----------------------------------------------------------------------------
module result_collector #(
    parameter int N            = 4,
    parameter int RESULT_WIDTH = 32,
    parameter int LATENCY      = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic [RESULT_WIDTH-1:0] row_in [0:N-1],
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    // Wait count at which the next enable cycle moves WAIT -> CAPTURE, so the
    // first capture lands on the LATENCY-th enable-high cycle after start.
    localparam logic [WW-1:0] WAIT_LAST  = WW'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    localparam logic [RW-1:0] COL_PENULT = RW'((N >= 2) ? N - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [WW-1:0]           wait_q;
    logic [RW-1:0]           cap_row_q;
    // Drain element index kept as a (row, column) pair so no divide is needed.
    logic [RW-1:0]           dr_row_q;
    logic [RW-1:0]           dr_col_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    done_q;
    logic [RESULT_WIDTH-1:0] mat_q [0:N-1][0:N-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            cap_row_q   <= '0;
            dr_row_q    <= '0;
            dr_col_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        wait_q    <= '0;
                        cap_row_q <= '0;
                        state_q   <= (LATENCY == 1) ? S_CAPTURE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (enable) begin
                        wait_q <= wait_q + 1'b1;
                        if (wait_q == WAIT_LAST) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (enable) begin
                        if (cap_row_q == ROW_LAST) begin
                            cap_row_q   <= '0;
                            dr_row_q    <= '0;
                            dr_col_q    <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (N == 1);
                            state_q     <= S_DRAIN;
                        end else begin
                            cap_row_q <= cap_row_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            if (dr_col_q == ROW_LAST) begin
                                dr_col_q <= '0;
                                dr_row_q <= dr_row_q + 1'b1;
                            end else begin
                                dr_col_q <= dr_col_q + 1'b1;
                            end
                            // Flag the next beat as last when it is C[N-1][N-1].
                            out_last_q <= (dr_row_q == ROW_LAST) && (dr_col_q == COL_PENULT);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Matrix buffer; stale contents are harmless because every row is
    // rewritten before the next drain.
    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE && enable) begin
            for (int j = 0; j < N; j++) begin
                mat_q[cap_row_q][j] <= row_in[j];
            end
        end
    end

    // Read straight from registers, so the value is stable while stalled.
    always_comb begin
        out_data = '0;
        if (state_q == S_DRAIN) begin
            out_data = mat_q[dr_row_q][dr_col_q];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_result_collector.sv
// -----------------------------------------------------------------------------
// tb_result_collector
//
// Bench for result_collector. Main instance uses N=4, LATENCY=11; a second
// instance uses LATENCY=1. Inputs change on the falling edge, outputs are
// observed on the falling edge. The reference model is the matrix itself:
// row r is presented on the (LATENCY+r)-th enable-high cycle after start, and
// the expected stream is the matrix flattened row-major into exp_q.
// -----------------------------------------------------------------------------
module tb_result_collector;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 11;
    localparam int NOMINAL_DONE = LAT + N - 1 + N * N + 1;
    localparam int LAT1_DONE    = 1 + N - 1 + N * N + 1;
    localparam logic [W-1:0] DEAD = 32'hDEAD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         enable, start, out_ready;
    logic [W-1:0] row_in [0:N-1];
    logic [W-1:0] out_data;
    logic         out_valid, out_last, busy, done;

    logic         enable1, start1, out_ready1;
    logic [W-1:0] row_in1 [0:N-1];
    logic [W-1:0] out_data1;
    logic         out_valid1, out_last1, busy1, done1;

    result_collector #(.N(N), .RESULT_WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .row_in(row_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    result_collector #(.N(N), .RESULT_WIDTH(W), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .start(start1),
        .row_in(row_in1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_last(out_last1), .busy(busy1), .done(done1)
    );

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mat [0:N-1][0:N-1];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    bit           last_q[$];
    int           done_cycle;
    int           stable_err;
    int           dead_seen;
    bit           timed_out;
    bit           busy_k1;

    // kind 0: 16*r+c, kind 1: random (never 0xDEAD), kind 2: 0x100+idx
    task automatic fill_mat(input int kind);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0:       mat[r][c] = W'(16 * r + c);
                    1:       mat[r][c] = $urandom() | 32'h0001_0000;
                    default: mat[r][c] = W'(32'h100 + r * N + c);
                endcase
            end
        end
        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_q.push_back(mat[r][c]);
    endtask

    // ---------------- driver ----------------
    // Runs one operation on the main instance. Returns at the falling edge of
    // the cycle in which done is seen (cycle 0 = start cycle), or right after
    // raising reset when abort_row2 is set.
    task automatic run_op(input bit stall_en, input bit toggle_rdy,
                          input bit extra_starts, input bit abort_row2,
                          input bit start_now);
        int           en_cnt = 0;
        int           sa = 0;
        int           sb = 0;
        int           r;
        bit           rdy_ph = 1'b1;
        bit           prev_hold = 1'b0;
        bit           row2_flag = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic         prev_last = 1'b0;
        got_q.delete();
        last_q.delete();
        done_cycle = -1;
        stable_err = 0;
        dead_seen  = 0;
        timed_out  = 1'b0;
        busy_k1    = 1'b0;
        if (!start_now) @(negedge clk);
        start = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) row_in[j] = DEAD;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) busy_k1 = busy;
            if (row2_flag) begin
                reset = 1'b1;
                return;
            end
            if (done) begin
                done_cycle = k;
                return;
            end
            if (out_valid) begin
                if (out_data == DEAD) dead_seen++;
                if (prev_hold && (out_data !== prev_data || out_last !== prev_last))
                    stable_err++;
            end
            if (toggle_rdy && out_valid) begin
                out_ready = rdy_ph;
                rdy_ph = ~rdy_ph;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (extra_starts && (k == 5 || (out_valid && out_ready && got_q.size() == 3)))
                start = 1'b1;
            enable = 1'b1;
            if (stall_en) begin
                if (en_cnt == 5 && sa < 2) begin
                    enable = 1'b0;
                    sa++;
                end else if (en_cnt == LAT + 2 && sb < 2) begin
                    enable = 1'b0;
                    sb++;
                end
            end
            if (enable) begin
                en_cnt++;
                r = en_cnt - LAT;
                for (int j = 0; j < N; j++) row_in[j] = DEAD;
                if (r >= 0 && r < N)
                    for (int j = 0; j < N; j++) row_in[j] = mat[r][j];
                if (abort_row2 && r == 2) row2_flag = 1'b1;
            end
        end
        timed_out = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; start = 1'b0; out_ready = 1'b0;
        enable1 = 1'b0; start1 = 1'b0; out_ready1 = 1'b0;
        for (int j = 0; j < N; j++) begin
            row_in[j] = DEAD;
            row_in1[j] = DEAD;
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b expected 0", out_last); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_cmp++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_lat1: got busy %b valid %b expected 0 0", busy1, out_valid1);
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        logic [W-1:0] e, g;
        bit l;
        fill_mat(0);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (timed_out) begin n_bad++; $display("FAIL nominal_timeout: got no done expected done"); end
        n_cmp++; if (done_cycle != NOMINAL_DONE) begin n_bad++; $display("FAIL nominal_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE); end
        n_cmp++; if (got_q.size() != N * N) begin n_bad++; $display("FAIL nominal_count: got %0d expected %0d", got_q.size(), N * N); end
        n_cmp++; if (dead_seen != 0) begin n_bad++; $display("FAIL nominal_dead: got %0d expected 0", dead_seen); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = 'x; l = 1'b0;
            if (got_q.size() > 0) begin g = got_q.pop_front(); l = last_q.pop_front(); end
            n_cmp++; if (g !== e || l != (i == N * N - 1)) begin
                n_bad++; $display("FAIL nominal_beat%0d: got %h last %b expected %h last %b", i, g, l, e, i == N * N - 1);
            end
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL nominal_done_pulse: got done %b busy %b expected 0 0", done, busy);
        end
    endtask

    task automatic test_enable_stalls();
        logic [W-1:0] e, g;
        fill_mat(1);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (done_cycle != NOMINAL_DONE + 4) begin n_bad++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE + 4); end
        n_cmp++; if (got_q.size() != N * N || dead_seen != 0) begin
            n_bad++; $display("FAIL stall_count: got %0d beats %0d dead expected %0d 0", got_q.size(), dead_seen, N * N);
        end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q[0] : 'x;
            if (got_q.size() > 0) void'(got_q.pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL stall_beat%0d: got %h expected %h", i, g, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e, g;
        bit l;
        fill_mat(1);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (done_cycle != NOMINAL_DONE + N * N - 1) begin
            n_bad++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE + N * N - 1);
        end
        n_cmp++; if (stable_err != 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes expected 0", stable_err); end
        n_cmp++; if (got_q.size() != N * N) begin n_bad++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), N * N); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = 'x; l = 1'b0;
            if (got_q.size() > 0) begin g = got_q.pop_front(); l = last_q.pop_front(); end
            n_cmp++; if (g !== e || l != (i == N * N - 1)) begin
                n_bad++; $display("FAIL bp_beat%0d: got %h last %b expected %h last %b", i, g, l, e, i == N * N - 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] e, g;
        int extra_done = 0;
        int extra_busy = 0;
        fill_mat(0);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (done_cycle != NOMINAL_DONE) begin n_bad++; $display("FAIL ign_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q[0] : 'x;
            if (got_q.size() > 0) void'(got_q.pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ign_beat%0d: got %h expected %h", i, g, e); end
        end
        repeat (4) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        n_cmp++; if (extra_done != 0 || extra_busy != 0) begin
            n_bad++; $display("FAIL ign_restart: got %0d done %0d busy cycles expected 0 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, g;
        fill_mat(1);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (got_q.size() != N * N || got_q[N * N - 1] !== exp_q[N * N - 1]) begin
            n_bad++; $display("FAIL b2b_first: got %0d beats expected %0d ending %h", got_q.size(), N * N, exp_q[N * N - 1]);
        end
        // Now in the done cycle: start the next matrix right here.
        fill_mat(1);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (busy_k1 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", busy_k1); end
        n_cmp++; if (done_cycle != NOMINAL_DONE) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q[0] : 'x;
            if (got_q.size() > 0) void'(got_q.pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_beat%0d: got %h expected %h", i, g, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e, g;
        fill_mat(1);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (done_cycle != -1 || got_q.size() != 0) begin
            n_bad++; $display("FAIL rst_mid_pre: got done %0d beats %0d expected -1 0", done_cycle, got_q.size());
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_state: got busy %b valid %b done %b expected 0 0 0", busy, out_valid, done);
        end
        reset = 1'b0;
        fill_mat(2);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (done_cycle != NOMINAL_DONE) begin n_bad++; $display("FAIL rst_mid_done_cycle: got %0d expected %0d", done_cycle, NOMINAL_DONE); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q[0] : 'x;
            if (got_q.size() > 0) void'(got_q.pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rst_mid_beat%0d: got %h expected %h", i, g, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_latency1();
        logic [W-1:0] e, g;
        int dc = -1;
        bit b1 = 1'b0;
        int r;
        fill_mat(1);
        got_q.delete();
        @(negedge clk);
        start1 = 1'b1; enable1 = 1'b1; out_ready1 = 1'b1;
        for (int j = 0; j < N; j++) row_in1[j] = DEAD;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (k == 1) b1 = busy1;
            if (done1) begin dc = k; break; end
            if (out_valid1) got_q.push_back(out_data1);
            r = k - 1;
            for (int j = 0; j < N; j++) row_in1[j] = DEAD;
            if (r < N)
                for (int j = 0; j < N; j++) row_in1[j] = mat[r][j];
        end
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL lat1_busy: got %b expected 1", b1); end
        n_cmp++; if (dc != LAT1_DONE) begin n_bad++; $display("FAIL lat1_done_cycle: got %0d expected %0d", dc, LAT1_DONE); end
        for (int i = 0; i < N * N; i++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q[0] : 'x;
            if (got_q.size() > 0) void'(got_q.pop_front());
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL lat1_beat%0d: got %h expected %h", i, g, e); end
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_enable_stalls();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
